// File: rtl/u712_pkg.sv
// Shared definitions for the U712 68000-to-local-bus bridge.
//   state_t      : bridge FSM states
//   SIZ_BYTE/WORD: local-bus SIZ encodings
//   strobe_size  : maps active-low UDS/LDS to {SIZ, A0}
package u712_pkg;

  typedef enum logic [2:0] {
    IDLE,
    STROBE,
    START,
    WAIT,
    ACK,
    RELEASE
  } state_t;

  localparam logic [1:0] SIZ_BYTE = 2'b01;
  localparam logic [1:0] SIZ_WORD = 2'b10;

  // Both strobes -> word at A0=0; UDS alone -> even byte; LDS alone -> odd byte.
  function automatic logic [2:0] strobe_size(input logic uds_n, input logic lds_n);
    if (!uds_n && !lds_n) return {SIZ_WORD, 1'b0};
    else if (!uds_n)      return {SIZ_BYTE, 1'b0};
    else                  return {SIZ_BYTE, 1'b1};
  endfunction

endpackage

// File: rtl/u712_sync2.sv
// Two-flop synchronizer for one asynchronous, active-low 68000 control input.
// Ports:
//   clk : sampling clock (rising edge)
//   rst : synchronous active-high reset; both flops reset to 1 (negated)
//   d   : asynchronous input
//   q   : synchronized output, two clock edges behind d
module u712_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/u712_m68k_lbus_bridge.sv
// Responder-side bridge: accepts an asynchronous 68000 bus cycle from the
// chipset side and issues one local-bus transfer, returning DTACKn when the
// transfer is acknowledged by TACKn, or BERRn if TACKn never comes.
// Ports:
//   CLK80, RESET                 : clock, synchronous active-high reset
//   ASn, UDSn, LDSn, M_RnW       : asynchronous 68000 strobes / direction
//   M_D_IN / M_D_OUT, M_D_OE     : 68000 write data / read data and its enable
//   DTACKn, BERRn                : 68000 termination, active low
//   TSn, L_RnW, SIZ, A0, L_D_OUT : local-bus transfer request
//   L_D_IN, TACKn                : local-bus read data and acknowledge
//   BUSY                         : high whenever the bridge is not IDLE
// TIMEOUT: CLK80 cycles waited for TACKn (1..255) before BERRn.
module u712_m68k_lbus_bridge
  import u712_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        CLK80,
  input  logic        RESET,
  input  logic        ASn,
  input  logic        UDSn,
  input  logic        LDSn,
  input  logic        M_RnW,
  input  logic [15:0] M_D_IN,
  output logic [15:0] M_D_OUT,
  output logic        M_D_OE,
  output logic        DTACKn,
  output logic        BERRn,
  output logic        TSn,
  output logic        L_RnW,
  output logic [1:0]  SIZ,
  output logic        A0,
  output logic [15:0] L_D_OUT,
  input  logic [15:0] L_D_IN,
  input  logic        TACKn,
  output logic        BUSY
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  logic s_as, s_uds, s_lds, s_rw;

  u712_sync2 u_sync_as  (.clk(CLK80), .rst(RESET), .d(ASn),   .q(s_as));
  u712_sync2 u_sync_uds (.clk(CLK80), .rst(RESET), .d(UDSn),  .q(s_uds));
  u712_sync2 u_sync_lds (.clk(CLK80), .rst(RESET), .d(LDSn),  .q(s_lds));
  u712_sync2 u_sync_rw  (.clk(CLK80), .rst(RESET), .d(M_RnW), .q(s_rw));

  state_t     state, state_nxt;
  logic [7:0] cnt;
  logic       latch_req, tack_hit, tmo_hit;
  logic       dtackn_nxt, berrn_nxt, m_d_oe_nxt;

  always_ff @(posedge CLK80) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    latch_req = 1'b0;
    tack_hit  = 1'b0;
    tmo_hit   = 1'b0;
    case (state)
      IDLE:    if (!s_as) state_nxt = STROBE;
      STROBE: begin
        // An address strobe that goes away before any data strobe aborts the cycle.
        if (s_as) begin
          state_nxt = IDLE;
        end else if (!s_uds || !s_lds) begin
          state_nxt = START;
          latch_req = 1'b1;
        end
      end
      START:   state_nxt = WAIT;
      WAIT: begin
        // TACKn is checked first so it wins on the timeout edge.
        if (!TACKn) begin
          state_nxt = ACK;
          tack_hit  = 1'b1;
        end else if (cnt == TMO_LAST) begin
          state_nxt = ACK;
          tmo_hit   = 1'b1;
        end
      end
      ACK:     if (s_as) state_nxt = RELEASE;
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // 68000-side terminations are set on entry to ACK and held while there.
    dtackn_nxt = 1'b1;
    berrn_nxt  = 1'b1;
    m_d_oe_nxt = 1'b0;
    if (tack_hit) begin
      dtackn_nxt = 1'b0;
      m_d_oe_nxt = L_RnW;
    end else if (tmo_hit) begin
      berrn_nxt = 1'b0;
    end else if (state == ACK && state_nxt == ACK) begin
      dtackn_nxt = DTACKn;
      berrn_nxt  = BERRn;
      m_d_oe_nxt = M_D_OE;
    end
  end

  // Outputs are registered from the next state so they are glitch-free and
  // change on the same edge as the state they belong to.
  always_ff @(posedge CLK80) begin
    if (RESET) begin
      TSn     <= 1'b1;
      DTACKn  <= 1'b1;
      BERRn   <= 1'b1;
      M_D_OE  <= 1'b0;
      M_D_OUT <= '0;
      L_D_OUT <= '0;
      L_RnW   <= 1'b1;
      SIZ     <= 2'b00;
      A0      <= 1'b0;
      BUSY    <= 1'b0;
      cnt     <= '0;
    end else begin
      TSn    <= (state_nxt != START);
      BUSY   <= (state_nxt != IDLE);
      DTACKn <= dtackn_nxt;
      BERRn  <= berrn_nxt;
      M_D_OE <= m_d_oe_nxt;

      if (latch_req) begin
        L_RnW     <= s_rw;
        {SIZ, A0} <= strobe_size(s_uds, s_lds);
        if (!s_rw) L_D_OUT <= M_D_IN;
      end

      if (state == START)     cnt <= '0;
      else if (state == WAIT) cnt <= cnt + 8'd1;

      if (tack_hit && L_RnW) M_D_OUT <= L_D_IN;
    end
  end

endmodule

// File: tb/tb_u712_m68k_lbus_bridge.sv
// Directed bench for u712_m68k_lbus_bridge. Two instances share all inputs:
// dut (TIMEOUT=16) is the main target, dut8 (TIMEOUT=8) covers the
// TACKn-on-timeout-edge case and a second timeout length.
module tb_u712_m68k_lbus_bridge;

  logic        CLK80 = 1'b0;
  logic        RESET = 1'b1;
  logic        ASn = 1'b1, UDSn = 1'b1, LDSn = 1'b1, M_RnW = 1'b1;
  logic [15:0] M_D_IN = '0, L_D_IN = '0;
  logic        TACKn = 1'b1;

  logic [15:0] M_D_OUT, L_D_OUT, M_D_OUT8, L_D_OUT8;
  logic        M_D_OE, DTACKn, BERRn, TSn, L_RnW, A0, BUSY;
  logic        M_D_OE8, DTACKn8, BERRn8, TSn8, L_RnW8, A08, BUSY8;
  logic [1:0]  SIZ, SIZ8;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK80 = ~CLK80;

  u712_m68k_lbus_bridge #(.TIMEOUT(16)) dut (
    .CLK80(CLK80), .RESET(RESET), .ASn(ASn), .UDSn(UDSn), .LDSn(LDSn),
    .M_RnW(M_RnW), .M_D_IN(M_D_IN), .M_D_OUT(M_D_OUT), .M_D_OE(M_D_OE),
    .DTACKn(DTACKn), .BERRn(BERRn), .TSn(TSn), .L_RnW(L_RnW), .SIZ(SIZ),
    .A0(A0), .L_D_OUT(L_D_OUT), .L_D_IN(L_D_IN), .TACKn(TACKn), .BUSY(BUSY)
  );

  u712_m68k_lbus_bridge #(.TIMEOUT(8)) dut8 (
    .CLK80(CLK80), .RESET(RESET), .ASn(ASn), .UDSn(UDSn), .LDSn(LDSn),
    .M_RnW(M_RnW), .M_D_IN(M_D_IN), .M_D_OUT(M_D_OUT8), .M_D_OE(M_D_OE8),
    .DTACKn(DTACKn8), .BERRn(BERRn8), .TSn(TSn8), .L_RnW(L_RnW8), .SIZ(SIZ8),
    .A0(A08), .L_D_OUT(L_D_OUT8), .L_D_IN(L_D_IN), .TACKn(TACKn), .BUSY(BUSY8)
  );

  // Counts falling clock edges until TSn is seen low (bounded at 20).
  task automatic wait_tsn(output int edges);
    edges = 0;
    while (TSn !== 1'b0 && edges < 20) begin
      @(negedge CLK80);
      edges++;
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (2) @(negedge CLK80);
    n_cmp++;
    if ({TSn, DTACKn, BERRn, M_D_OE, BUSY, L_RnW, SIZ, A0} !== 9'b1110_0100_0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b want %b", {TSn, DTACKn, BERRn, M_D_OE, BUSY, L_RnW, SIZ, A0}, 9'b1110_0100_0);
    end
    n_cmp++;
    if ({M_D_OUT, L_D_OUT} !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_data: got %h want 00000000", {M_D_OUT, L_D_OUT});
    end
    RESET = 1'b0;
    @(negedge CLK80);
  endtask

  task automatic test_word_write();
    int edges;
    ASn = 1'b0; UDSn = 1'b0; LDSn = 1'b0; M_RnW = 1'b0; M_D_IN = 16'hA55A;
    wait_tsn(edges);
    n_cmp++;
    if (edges != 4) begin n_bad++; $display("FAIL ww_ts_latency: got %0d want 4", edges); end
    n_cmp++;
    if ({SIZ, A0, L_RnW, BUSY} !== 5'b10_0_0_1) begin
      n_bad++; $display("FAIL ww_siz_a0_rw_busy: got %b want 10001", {SIZ, A0, L_RnW, BUSY});
    end
    n_cmp++;
    if (L_D_OUT !== 16'hA55A) begin n_bad++; $display("FAIL ww_ldout: got %h want a55a", L_D_OUT); end
    @(negedge CLK80);
    n_cmp++;
    if (TSn !== 1'b1) begin n_bad++; $display("FAIL ww_ts_one_cycle: got %b want 1", TSn); end
    @(negedge CLK80);
    TACKn = 1'b0;
    n_cmp++;
    if (DTACKn !== 1'b1) begin n_bad++; $display("FAIL ww_dtack_early: got %b want 1", DTACKn); end
    @(negedge CLK80);
    TACKn = 1'b1;
    n_cmp++;
    if ({DTACKn, BERRn, M_D_OE, TSn} !== 4'b0101) begin
      n_bad++; $display("FAIL ww_ack: got %b want 0101", {DTACKn, BERRn, M_D_OE, TSn});
    end
    repeat (3) @(negedge CLK80);
    n_cmp++;
    if (DTACKn !== 1'b0) begin n_bad++; $display("FAIL ww_dtack_hold: got %b want 0", DTACKn); end
    ASn = 1'b1; UDSn = 1'b1; LDSn = 1'b1;
    repeat (2) @(negedge CLK80);
    n_cmp++;
    if (DTACKn !== 1'b0) begin n_bad++; $display("FAIL ww_dtack_neg_early: got %b want 0", DTACKn); end
    @(negedge CLK80);
    n_cmp++;
    if (DTACKn !== 1'b1) begin n_bad++; $display("FAIL ww_dtack_neg: got %b want 1", DTACKn); end
    @(negedge CLK80);
    n_cmp++;
    if (BUSY !== 1'b0) begin n_bad++; $display("FAIL ww_idle: got %b want 0", BUSY); end
  endtask

  task automatic test_byte_read();
    int edges;
    ASn = 1'b0; UDSn = 1'b1; LDSn = 1'b0; M_RnW = 1'b1; M_D_IN = 16'h1234;
    wait_tsn(edges);
    n_cmp++;
    if (edges != 4) begin n_bad++; $display("FAIL br_ts_latency: got %0d want 4", edges); end
    n_cmp++;
    if ({SIZ, A0, L_RnW} !== 4'b01_1_1) begin
      n_bad++; $display("FAIL br_siz_a0_rw: got %b want 0111", {SIZ, A0, L_RnW});
    end
    @(negedge CLK80);
    TACKn = 1'b0; L_D_IN = 16'h00C3;
    @(negedge CLK80);
    TACKn = 1'b1; L_D_IN = 16'hFFFF;
    n_cmp++;
    if ({M_D_OUT, M_D_OE, DTACKn, BERRn} !== {16'h00C3, 3'b101}) begin
      n_bad++; $display("FAIL br_ack: got %h/%b want 00c3/101", M_D_OUT, {M_D_OE, DTACKn, BERRn});
    end
    @(negedge CLK80);
    n_cmp++;
    if ({M_D_OUT, L_D_OUT} !== {16'h00C3, 16'hA55A}) begin
      n_bad++; $display("FAIL br_data_hold: got %h want 00c3a55a", {M_D_OUT, L_D_OUT});
    end
    ASn = 1'b1; LDSn = 1'b1;
    repeat (2) @(negedge CLK80);
    n_cmp++;
    if ({M_D_OE, DTACKn} !== 2'b10) begin n_bad++; $display("FAIL br_oe_early: got %b want 10", {M_D_OE, DTACKn}); end
    @(negedge CLK80);
    n_cmp++;
    if ({M_D_OE, DTACKn} !== 2'b01) begin n_bad++; $display("FAIL br_oe_drop: got %b want 01", {M_D_OE, DTACKn}); end
    @(negedge CLK80);
  endtask

  task automatic test_timeout();
    int edges, n, n8;
    ASn = 1'b0; UDSn = 1'b0; LDSn = 1'b0; M_RnW = 1'b1; TACKn = 1'b1;
    wait_tsn(edges);
    n = 0; n8 = 0;
    while (BERRn !== 1'b0 && n < 40) begin
      @(negedge CLK80);
      n++;
      if (BERRn8 === 1'b0 && n8 == 0) n8 = n;
    end
    n_cmp++;
    if (n != 17) begin n_bad++; $display("FAIL to_latency16: got %0d want 17", n); end
    n_cmp++;
    if (n8 != 9) begin n_bad++; $display("FAIL to_latency8: got %0d want 9", n8); end
    n_cmp++;
    if ({DTACKn, M_D_OE} !== 2'b10) begin n_bad++; $display("FAIL to_no_dtack: got %b want 10", {DTACKn, M_D_OE}); end
    ASn = 1'b1; UDSn = 1'b1; LDSn = 1'b1;
    repeat (4) @(negedge CLK80);
    n_cmp++;
    if ({BUSY, BERRn, DTACKn} !== 3'b011) begin n_bad++; $display("FAIL to_release: got %b want 011", {BUSY, BERRn, DTACKn}); end
  endtask

  task automatic test_abort();
    int  tsn_low;
    logic b2, b3, b7;
    tsn_low = 0; b2 = 1'bx; b3 = 1'bx; b7 = 1'bx;
    ASn = 1'b0; UDSn = 1'b1; LDSn = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge CLK80);
      if (TSn === 1'b0) tsn_low++;
      if (i == 2) b2 = BUSY;
      if (i == 3) b3 = BUSY;
      if (i == 7) b7 = BUSY;
      if (i == 4) ASn = 1'b1;
    end
    n_cmp++;
    if (tsn_low != 0) begin n_bad++; $display("FAIL ab_no_ts: got %0d want 0", tsn_low); end
    n_cmp++;
    if ({b2, b3, b7} !== 3'b010) begin n_bad++; $display("FAIL ab_busy: got %b want 010", {b2, b3, b7}); end
  endtask

  task automatic test_reset_in_wait();
    int   edges;
    logic dtack_seen, busy_seen;
    ASn = 1'b0; UDSn = 1'b0; LDSn = 1'b0; M_RnW = 1'b0; M_D_IN = 16'h1357;
    wait_tsn(edges);
    @(negedge CLK80);
    RESET = 1'b1; ASn = 1'b1; UDSn = 1'b1; LDSn = 1'b1;
    @(negedge CLK80);
    n_cmp++;
    if ({TSn, DTACKn, BERRn, M_D_OE, BUSY, L_RnW, SIZ, A0} !== 9'b1110_0100_0) begin
      n_bad++; $display("FAIL rw_ctrl: got %b want 111001000", {TSn, DTACKn, BERRn, M_D_OE, BUSY, L_RnW, SIZ, A0});
    end
    n_cmp++;
    if ({M_D_OUT, L_D_OUT} !== 32'h0) begin n_bad++; $display("FAIL rw_data: got %h want 00000000", {M_D_OUT, L_D_OUT}); end
    RESET = 1'b0; TACKn = 1'b0;
    dtack_seen = 1'b0; busy_seen = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge CLK80);
      if (DTACKn === 1'b0) dtack_seen = 1'b1;
      if (BUSY === 1'b1) busy_seen = 1'b1;
      if (i == 2) TACKn = 1'b1;
    end
    n_cmp++;
    if ({dtack_seen, busy_seen} !== 2'b00) begin n_bad++; $display("FAIL rw_ignored: got %b want 00", {dtack_seen, busy_seen}); end
    ASn = 1'b0; UDSn = 1'b0; LDSn = 1'b1; M_RnW = 1'b1;
    wait_tsn(edges);
    n_cmp++;
    if ({SIZ, A0, L_RnW} !== 4'b01_0_1 || edges != 4) begin
      n_bad++; $display("FAIL rw_next_req: got %b/%0d want 0101/4", {SIZ, A0, L_RnW}, edges);
    end
    @(negedge CLK80);
    TACKn = 1'b0; L_D_IN = 16'hBEEF;
    @(negedge CLK80);
    TACKn = 1'b1;
    n_cmp++;
    if ({M_D_OUT, M_D_OE, DTACKn} !== {16'hBEEF, 2'b10}) begin
      n_bad++; $display("FAIL rw_next_ack: got %h/%b want beef/10", M_D_OUT, {M_D_OE, DTACKn});
    end
    ASn = 1'b1; UDSn = 1'b1;
    repeat (4) @(negedge CLK80);
    n_cmp++;
    if ({BUSY, DTACKn} !== 2'b01) begin n_bad++; $display("FAIL rw_next_idle: got %b want 01", {BUSY, DTACKn}); end
  endtask

  task automatic test_tack_on_timeout_edge();
    int edges;
    ASn = 1'b0; UDSn = 1'b0; LDSn = 1'b0; M_RnW = 1'b1;
    wait_tsn(edges);
    repeat (8) @(negedge CLK80);
    n_cmp++;
    if ({DTACKn8, BERRn8} !== 2'b11) begin n_bad++; $display("FAIL te_before: got %b want 11", {DTACKn8, BERRn8}); end
    TACKn = 1'b0; L_D_IN = 16'h5AA5;
    @(negedge CLK80);
    TACKn = 1'b1;
    n_cmp++;
    if ({DTACKn8, BERRn8, M_D_OE8} !== 3'b011) begin
      n_bad++; $display("FAIL te_tack_wins: got %b want 011", {DTACKn8, BERRn8, M_D_OE8});
    end
    n_cmp++;
    if (M_D_OUT8 !== 16'h5AA5) begin n_bad++; $display("FAIL te_data: got %h want 5aa5", M_D_OUT8); end
    ASn = 1'b1; UDSn = 1'b1; LDSn = 1'b1;
    repeat (4) @(negedge CLK80);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_word_write();
    test_byte_read();
    test_timeout();
    test_abort();
    test_reset_in_wait();
    test_tack_on_timeout_edge();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
